game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Two-player turn sequencer for the VGA obstacle-crossing game. It owns the game state, the per-player scores and the per-turn countdown. It also drives the obstacle/player datapath: a one-cycle level reload pulse and a freeze level. It sits between the board switches/buttons and the row/player datapath, and its outputs feed the LED and SSD decode.

## Interface
Parameters:
- WIN_SCORE, 10, score at which a player wins; ≤ 15
- TURN_TICKS, 30, ticks per turn; ≤ 63
- HIT_PENALTY, 5, ticks removed from the turn per collision

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  level switch; a 0→1 transition begins a game
- restart  in  1  one-cycle pulse (debounced centre button); abort to idle
- tick  in  1  one-cycle move-rate enable from the clock divider
- win_evt  in  1  one-cycle pulse; player reached the ending row
- hit_evt  in  1  one-cycle pulse; player collided with an obstacle
- state  out  2  00 QI, 01 QGAME_1, 10 QGAME_2, 11 QDONE
- p1_score, p2_score  out  4 each  scores
- time_left  out  6  remaining ticks in the current turn
- level_reset  out  1  one-cycle pulse; reload obstacle rows and player start position
- freeze  out  1  high, hold the datapath
- winner  out  1  0 = player 1, 1 = player 2; valid in QDONE

## Operation
- Reset (reset_n = 0 at a clk edge) sets:
  - state = QI, scores = 0, time_left = TURN_TICKS
  - level_reset = 0, freeze = 1, winner = 0
  - start_d (registered start) = current start, so a switch left high does not auto-start.
- Rising-edge detect: start & ~start_d.
- QI:
  - freeze = 1, scores held at 0.
  - start rising → QGAME_1, time_left = TURN_TICKS, level_reset pulse, freeze = 0.
- QGAME_1 / QGAME_2 (active player = state[1]). Per cycle, first match wins:
  1. restart → QI, scores = 0, freeze = 1, no level_reset.
  2. win_evt → active score + 1.
     - New score == WIN_SCORE → QDONE, winner = active player, freeze = 1.
     - Otherwise → other player's state, time_left = TURN_TICKS, level_reset pulse.
  3. tick with time_left == 0 → timeout. Scores unchanged; switch player, time_left = TURN_TICKS, level_reset pulse.
  4. Otherwise time_left = max(0, time_left − tick − (hit_evt ? HIT_PENALTY : 0)).
     - Compute at 7 bits; clamp to 0, never wrap.
     - A hit does not switch the turn. Respawn is handled by the datapath.
- QDONE:
  - freeze = 1, scores and winner held.
  - restart → QI with scores cleared.
  - start rising → QGAME_1 with scores cleared, level_reset pulse.
- win_evt, hit_evt and tick are ignored in QI and QDONE.
- Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered. An event sampled at edge n is reflected in outputs after edge n.
- level_reset is high for exactly one cycle, the cycle after the triggering event, and never on two consecutive cycles.
- freeze changes in the same cycle as state.
- Simultaneous win_evt and tick at time_left == 0: win takes priority and the score counts.
- Simultaneous tick and hit_evt: both subtract, then clamp to 0 (e.g. 3 − 1 − 5 → 0). Timeout fires on the next tick.
- reset_n low mid-turn: returns to reset values at that edge; no level_reset is emitted.

## Structure
- Shared package game_pkg:
  - state encodings QI/QGAME_1/QGAME_2/QDONE, matching the LED decode
  - TIME_W = 6, SCORE_W = 4
- One sub-module, turn_timer:
  - inputs: load, tick, hit
  - outputs: time_left, expired (time_left == 0)
  - performs the saturating subtract
- The FSM, edge detect and score registers stay in game_flow_ctrl.

## Test plan
- Reset with start = 1 held → state 00, freeze = 1, time_left = 30; no start after 5 cycles. Toggle start 0→1 → state 01, level_reset one cycle, freeze = 0.
- In QGAME_1, 31 ticks with no events → the 31st tick at time_left = 0 produces state 10, time_left = 30, level_reset pulse; scores 0/0.
- time_left = 3, tick and hit_evt in the same cycle → time_left = 0. Next tick → timeout to the other player.
- p1_score = 9 in QGAME_1, win_evt → p1_score = 10, state 11, winner = 0, freeze = 1, no level_reset. Later win_evt/tick → no change.
- win_evt and timeout tick in the same cycle at p2_score = 4 in QGAME_2 → p2_score = 5, state 01.
- restart mid-QGAME_2 with scores 3/7 → state 00, scores 0/0, freeze = 1. reset_n low mid-turn → all reset values next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the two-player game flow controller: state encodings
// that match the LED decode, datapath widths and a turn-handover helper.
package game_pkg;

    localparam int TIME_W  = 6;
    localparam int SCORE_W = 4;

    localparam logic [1:0] QI      = 2'b00;
    localparam logic [1:0] QGAME_1 = 2'b01;
    localparam logic [1:0] QGAME_2 = 2'b10;
    localparam logic [1:0] QDONE   = 2'b11;

    // Hands the turn to the other player; anything unexpected goes back to player 1.
    function automatic logic [1:0] other_player(input logic [1:0] cur_state);
        logic [1:0] nxt;
        case (cur_state)
            QGAME_1: nxt = QGAME_2;
            QGAME_2: nxt = QGAME_1;
            default: nxt = QGAME_1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Board-side bundle of the game flow controller: switch/button/datapath events
// in, game state, scores and datapath control out.
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic                 start;
    logic                 restart;
    logic                 tick;
    logic                 win_evt;
    logic                 hit_evt;
    logic [1:0]           state;
    logic [SCORE_W-1:0]   p1_score;
    logic [SCORE_W-1:0]   p2_score;
    logic [TIME_W-1:0]    time_left;
    logic                 level_reset;
    logic                 freeze;
    logic                 winner;

    modport master (
        output start, restart, tick, win_evt, hit_evt,
        input  state, p1_score, p2_score, time_left, level_reset, freeze, winner
    );

    modport slave (
        input  start, restart, tick, win_evt, hit_evt,
        output state, p1_score, p2_score, time_left, level_reset, freeze, winner
    );

endinterface

// File: rtl/game_flow_ctrl_turn_timer.sv
// Per-turn countdown: reloads to TURN_TICKS on load, otherwise subtracts one per
// tick plus a penalty per hit, saturating at zero.
module turn_timer
    import game_pkg::*;
#(
    parameter int TURN_TICKS  = 30,
    parameter int HIT_PENALTY = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              tick,
    input  logic              hit,
    output logic [TIME_W-1:0] time_left,
    output logic              expired
);

    logic [TIME_W-1:0] time_left_r;
    logic [TIME_W:0]   cur_s;
    logic [TIME_W:0]   dec_s;
    logic [TIME_W:0]   diff_s;

    // Saturating subtract one bit wider than the counter so a large penalty never wraps.
    always_comb begin
        cur_s = {1'b0, time_left_r};
        dec_s = {{TIME_W{1'b0}}, tick} + (hit ? (TIME_W+1)'(HIT_PENALTY) : {(TIME_W+1){1'b0}});
        if (dec_s > cur_s) begin
            diff_s = {(TIME_W+1){1'b0}};
        end else begin
            diff_s = cur_s - dec_s;
        end
    end

    // Countdown register; reload wins over any decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            time_left_r <= TIME_W'(TURN_TICKS);
        end else if (load) begin
            time_left_r <= TIME_W'(TURN_TICKS);
        end else if (tick || hit) begin
            time_left_r <= diff_s[TIME_W-1:0];
        end else begin
            time_left_r <= time_left_r;
        end
    end

    assign time_left = time_left_r;
    assign expired   = (time_left_r == {TIME_W{1'b0}});

endmodule

// File: rtl/game_flow_ctrl.sv
// Two-player turn sequencer: owns game state, scores and the turn countdown, and
// drives the datapath reload pulse and freeze level.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = 10,
    parameter int TURN_TICKS  = 30,
    parameter int HIT_PENALTY = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    game_flow_ctrl_if.slave  bus
);

    logic [1:0]         state_r;
    logic [SCORE_W-1:0] p1_score_r;
    logic [SCORE_W-1:0] p2_score_r;
    logic               winner_r;
    logic               freeze_r;
    logic               level_reset_r;
    logic               start_d_r;

    logic [1:0]         state_n_s;
    logic [SCORE_W-1:0] p1_score_n_s;
    logic [SCORE_W-1:0] p2_score_n_s;
    logic               winner_n_s;
    logic               freeze_n_s;
    logic               reload_s;
    logic               load_s;
    logic               tmr_tick_s;
    logic               tmr_hit_s;
    logic               active_s;
    logic               start_rise_s;
    logic [SCORE_W-1:0] score_inc_s;
    logic [TIME_W-1:0]  time_left_s;
    logic               expired_s;

    assign start_rise_s = bus.start & ~start_d_r;
    assign active_s     = state_r[1];
    assign score_inc_s  = (active_s ? p2_score_r : p1_score_r) + {{(SCORE_W-1){1'b0}}, 1'b1};

    turn_timer #(
        .TURN_TICKS  (TURN_TICKS),
        .HIT_PENALTY (HIT_PENALTY)
    ) u_turn_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_s),
        .tick      (tmr_tick_s),
        .hit       (tmr_hit_s),
        .time_left (time_left_s),
        .expired   (expired_s)
    );

    // Next-state logic; inside a turn the order restart > win > timeout > countdown decides.
    always_comb begin
        state_n_s    = state_r;
        p1_score_n_s = p1_score_r;
        p2_score_n_s = p2_score_r;
        winner_n_s   = winner_r;
        freeze_n_s   = freeze_r;
        reload_s     = 1'b0;
        load_s       = 1'b0;
        tmr_tick_s   = 1'b0;
        tmr_hit_s    = 1'b0;
        case (state_r)
            QI: begin
                p1_score_n_s = {SCORE_W{1'b0}};
                p2_score_n_s = {SCORE_W{1'b0}};
                if (start_rise_s) begin
                    state_n_s  = QGAME_1;
                    freeze_n_s = 1'b0;
                    load_s     = 1'b1;
                    reload_s   = 1'b1;
                end else begin
                    state_n_s  = QI;
                    freeze_n_s = 1'b1;
                end
            end
            QGAME_1, QGAME_2: begin
                if (bus.restart) begin
                    state_n_s    = QI;
                    p1_score_n_s = {SCORE_W{1'b0}};
                    p2_score_n_s = {SCORE_W{1'b0}};
                    freeze_n_s   = 1'b1;
                    load_s       = 1'b1;
                end else if (bus.win_evt) begin
                    if (active_s) begin
                        p2_score_n_s = score_inc_s;
                    end else begin
                        p1_score_n_s = score_inc_s;
                    end
                    if (score_inc_s == SCORE_W'(WIN_SCORE)) begin
                        state_n_s  = QDONE;
                        winner_n_s = active_s;
                        freeze_n_s = 1'b1;
                    end else begin
                        state_n_s = other_player(state_r);
                        load_s    = 1'b1;
                        reload_s  = 1'b1;
                    end
                end else if (bus.tick && expired_s) begin
                    state_n_s = other_player(state_r);
                    load_s    = 1'b1;
                    reload_s  = 1'b1;
                end else begin
                    tmr_tick_s = bus.tick;
                    tmr_hit_s  = bus.hit_evt;
                end
            end
            QDONE: begin
                if (bus.restart) begin
                    state_n_s    = QI;
                    p1_score_n_s = {SCORE_W{1'b0}};
                    p2_score_n_s = {SCORE_W{1'b0}};
                    freeze_n_s   = 1'b1;
                    load_s       = 1'b1;
                end else if (start_rise_s) begin
                    state_n_s    = QGAME_1;
                    p1_score_n_s = {SCORE_W{1'b0}};
                    p2_score_n_s = {SCORE_W{1'b0}};
                    freeze_n_s   = 1'b0;
                    load_s       = 1'b1;
                    reload_s     = 1'b1;
                end else begin
                    state_n_s  = QDONE;
                    freeze_n_s = 1'b1;
                end
            end
            default: begin
                state_n_s  = QI;
                freeze_n_s = 1'b1;
                load_s     = 1'b1;
            end
        endcase
    end

    // State, score and control registers; a reload request right after a pulse is
    // absorbed so the datapath never sees back-to-back reloads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= QI;
            p1_score_r    <= {SCORE_W{1'b0}};
            p2_score_r    <= {SCORE_W{1'b0}};
            winner_r      <= 1'b0;
            freeze_r      <= 1'b1;
            level_reset_r <= 1'b0;
            start_d_r     <= bus.start;
        end else begin
            state_r       <= state_n_s;
            p1_score_r    <= p1_score_n_s;
            p2_score_r    <= p2_score_n_s;
            winner_r      <= winner_n_s;
            freeze_r      <= freeze_n_s;
            level_reset_r <= reload_s & ~level_reset_r;
            start_d_r     <= bus.start;
        end
    end

    assign bus.state       = state_r;
    assign bus.p1_score    = p1_score_r;
    assign bus.p2_score    = p2_score_r;
    assign bus.time_left   = time_left_s;
    assign bus.level_reset = level_reset_r;
    assign bus.freeze      = freeze_r;
    assign bus.winner      = winner_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset, start, timeouts, hits, wins,
// priority corner cases, restart and mid-turn reset.
module tb_game_flow_ctrl;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .WIN_SCORE   (10),
        .TURN_TICKS  (30),
        .HIT_PENALTY (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_win();
        bus.win_evt = 1'b1;
        cyc(1);
        bus.win_evt = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b1;
        bus.restart = 1'b0;
        bus.tick    = 1'b0;
        bus.win_evt = 1'b0;
        bus.hit_evt = 1'b0;
        cyc(2);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_freeze", 32'(bus.freeze), 32'd1);
        chk("rst_time", 32'(bus.time_left), 32'd30);
        chk("rst_lr", 32'(bus.level_reset), 32'd0);
        chk("rst_p1", 32'(bus.p1_score), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        reset_n = 1'b1;
        cyc(5);
        chk("no_autostart", 32'(bus.state), 32'd0);

        bus.start = 1'b0;
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_lr", 32'(bus.level_reset), 32'd1);
        chk("start_freeze", 32'(bus.freeze), 32'd0);
        chk("start_time", 32'(bus.time_left), 32'd30);

        // 30 ticks drain the turn, the 31st times out
        bus.tick = 1'b1;
        cyc(1);
        chk("lr_one_cycle", 32'(bus.level_reset), 32'd0);
        chk("tick_dec", 32'(bus.time_left), 32'd29);
        cyc(29);
        chk("time_zero", 32'(bus.time_left), 32'd0);
        chk("still_p1", 32'(bus.state), 32'd1);
        cyc(1);
        bus.tick = 1'b0;
        chk("timeout_state", 32'(bus.state), 32'd2);
        chk("timeout_time", 32'(bus.time_left), 32'd30);
        chk("timeout_lr", 32'(bus.level_reset), 32'd1);
        chk("timeout_p1", 32'(bus.p1_score), 32'd0);
        chk("timeout_p2", 32'(bus.p2_score), 32'd0);

        // drain to 3, then tick+hit clamps at 0
        bus.tick = 1'b1;
        cyc(27);
        chk("time_three", 32'(bus.time_left), 32'd3);
        bus.hit_evt = 1'b1;
        cyc(1);
        bus.hit_evt = 1'b0;
        chk("clamp_zero", 32'(bus.time_left), 32'd0);
        chk("hit_no_switch", 32'(bus.state), 32'd2);
        cyc(1);
        bus.tick = 1'b0;
        chk("clamp_timeout", 32'(bus.state), 32'd1);
        chk("clamp_reload", 32'(bus.time_left), 32'd30);

        bus.hit_evt = 1'b1;
        cyc(1);
        bus.hit_evt = 1'b0;
        chk("hit_only", 32'(bus.time_left), 32'd25);

        // nine rounds of alternating wins bring scores to 9/9
        for (int r = 0; r < 9; r++) begin
            pulse_win();
            cyc(1);
            pulse_win();
            cyc(1);
        end
        chk("p1_nine", 32'(bus.p1_score), 32'd9);
        chk("p2_nine", 32'(bus.p2_score), 32'd9);
        chk("back_p1", 32'(bus.state), 32'd1);

        pulse_win();
        chk("win_p1", 32'(bus.p1_score), 32'd10);
        chk("win_state", 32'(bus.state), 32'd3);
        chk("win_who", 32'(bus.winner), 32'd0);
        chk("win_freeze", 32'(bus.freeze), 32'd1);
        chk("win_no_lr", 32'(bus.level_reset), 32'd0);
        bus.tick = 1'b1;
        pulse_win();
        bus.tick = 1'b0;
        chk("done_hold_state", 32'(bus.state), 32'd3);
        chk("done_hold_p1", 32'(bus.p1_score), 32'd10);
        chk("done_hold_p2", 32'(bus.p2_score), 32'd9);

        // new game from QDONE clears scores
        bus.start = 1'b0;
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        chk("regame_state", 32'(bus.state), 32'd1);
        chk("regame_p1", 32'(bus.p1_score), 32'd0);
        chk("regame_lr", 32'(bus.level_reset), 32'd1);
        chk("regame_freeze", 32'(bus.freeze), 32'd0);
        cyc(1);

        for (int r = 0; r < 4; r++) begin
            pulse_win();
            cyc(1);
            pulse_win();
            cyc(1);
        end
        pulse_win();
        cyc(1);
        chk("p2_four", 32'(bus.p2_score), 32'd4);
        chk("in_p2", 32'(bus.state), 32'd2);
        bus.tick = 1'b1;
        cyc(30);
        chk("p2_time_zero", 32'(bus.time_left), 32'd0);
        bus.win_evt = 1'b1;
        cyc(1);
        bus.win_evt = 1'b0;
        bus.tick    = 1'b0;
        chk("win_prio_p2", 32'(bus.p2_score), 32'd5);
        chk("win_prio_state", 32'(bus.state), 32'd1);
        chk("win_prio_p1", 32'(bus.p1_score), 32'd5);

        cyc(1);
        pulse_win();
        chk("pre_restart", 32'(bus.state), 32'd2);
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
        chk("restart_state", 32'(bus.state), 32'd0);
        chk("restart_p1", 32'(bus.p1_score), 32'd0);
        chk("restart_p2", 32'(bus.p2_score), 32'd0);
        chk("restart_freeze", 32'(bus.freeze), 32'd1);
        chk("restart_no_lr", 32'(bus.level_reset), 32'd0);

        bus.tick = 1'b1;
        pulse_win();
        bus.tick = 1'b0;
        chk("idle_ignore_state", 32'(bus.state), 32'd0);
        chk("idle_ignore_p1", 32'(bus.p1_score), 32'd0);

        // reset in the middle of a turn
        bus.start = 1'b0;
        cyc(1);
        bus.start = 1'b1;
        cyc(2);
        bus.tick = 1'b1;
        cyc(2);
        bus.tick = 1'b0;
        chk("mid_time", 32'(bus.time_left), 32'd28);
        reset_n = 1'b0;
        cyc(1);
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_time", 32'(bus.time_left), 32'd30);
        chk("midrst_freeze", 32'(bus.freeze), 32'd1);
        chk("midrst_lr", 32'(bus.level_reset), 32'd0);
        reset_n = 1'b1;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
